adder_accum_unit: RTL and testbench

Parametrised successor to the two-operand adder in the keypad-to-display sum path. It runs in either single mode, computing number1 ± number2, or accumulate mode, computing a running total of number1 terms with add/subtract. The block uses a start/busy/valid handshake and raises overflow and term-limit flags. It sits between the BCD-to-binary operand readers and the result display formatter, all on the 27 MHz clk domain.

---
 rtl/adder_accum_unit.sv | 146 ++++++++++++++
 tb/tb_adder_accum_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_accum_unit.sv
// Single/accumulate adder with a start/busy/valid handshake and overflow and term-limit flags.
// Build option: define ADDER_SATURATE_EN to clamp accumulator overflow/underflow instead of wrapping.
module adder_accum_unit #(
   parameter int WIDTH     = 12,
   parameter int MAX_TERMS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] number1,
   input  logic [WIDTH-1:0] number2,
   input  logic             op,
   input  logic             mode,
   input  logic             enable,
   input  logic             clear,
   output logic [WIDTH:0]   sum_result,
   output logic             sum_state,
   output logic             busy,
   output logic             negative,
   output logic             overflow,
   output logic [7:0]       term_count,
   output logic             term_err
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   localparam logic [WIDTH:0] ACC_MAX   = '1;
   localparam logic [7:0]     MAX_T     = 8'(MAX_TERMS);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_op;
   logic             r_mode;
   logic [WIDTH:0]   r_acc;
   logic [WIDTH:0]   r_sum;
   logic             r_sum_state;
   logic             r_busy;
   logic             r_neg;
   logic             r_ovf;
   logic [7:0]       r_terms;
   logic             r_term_err;

   logic [WIDTH+1:0] w_acc_add;
   logic [WIDTH+1:0] w_acc_sub;
   logic [WIDTH:0]   w_single_add;
   logic [WIDTH-1:0] w_single_diff;
   logic             w_a_lt_b;
   logic [WIDTH:0]   w_acc_next;
   logic             w_acc_ovf;

   always_comb begin
      w_acc_add     = {1'b0, r_acc} + {2'b00, r_a};
      w_acc_sub     = {1'b0, r_acc} - {2'b00, r_a};
      w_single_add  = {1'b0, r_a} + {1'b0, r_b};
      w_a_lt_b      = (r_a < r_b);
      w_single_diff = w_a_lt_b ? (r_b - r_a) : (r_a - r_b);
      w_acc_next    = '0;
      w_acc_ovf     = 1'b0;
      // Bit WIDTH+1 of the extended add/sub is the carry or borrow out of the accumulator.
      if (r_op) begin
         w_acc_ovf  = w_acc_sub[WIDTH+1];
`ifdef ADDER_SATURATE_EN
         w_acc_next = w_acc_ovf ? '0 : w_acc_sub[WIDTH:0];
`else
         w_acc_next = w_acc_sub[WIDTH:0];
`endif
      end else begin
         w_acc_ovf  = w_acc_add[WIDTH+1];
`ifdef ADDER_SATURATE_EN
         w_acc_next = w_acc_ovf ? ACC_MAX : w_acc_add[WIDTH:0];
`else
         w_acc_next = w_acc_add[WIDTH:0];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= 1'b0;
         r_mode      <= 1'b0;
         r_acc       <= '0;
         r_sum       <= '0;
         r_sum_state <= 1'b0;
         r_busy      <= 1'b0;
         r_neg       <= 1'b0;
         r_ovf       <= 1'b0;
         r_terms     <= '0;
         r_term_err  <= 1'b0;
      end else begin
         r_sum_state <= 1'b0;
         r_term_err  <= 1'b0;
         // busy trails the state by one cycle so it covers the CALC and DONE cycles' outputs.
         r_busy      <= (r_state != S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (clear) begin
                  r_acc   <= '0;
                  r_terms <= '0;
                  r_ovf   <= 1'b0;
               end else if (enable) begin
                  if (mode && (r_terms == MAX_T)) begin
                     r_term_err <= 1'b1;
                  end else begin
                     r_a     <= number1;
                     r_b     <= number2;
                     r_op    <= op;
                     r_mode  <= mode;
                     r_state <= S_CALC;
                  end
               end
            end
            S_CALC: r_state <= S_DONE;
            S_DONE: begin
               r_state     <= S_IDLE;
               r_sum_state <= 1'b1;
               if (r_mode) begin
                  r_acc   <= w_acc_next;
                  r_sum   <= w_acc_next;
                  r_neg   <= 1'b0;
                  r_terms <= r_terms + 8'd1;
                  if (w_acc_ovf) r_ovf <= 1'b1;
               end else if (r_op) begin
                  r_sum <= {1'b0, w_single_diff};
                  r_neg <= w_a_lt_b;
               end else begin
                  r_sum <= w_single_add;
                  r_neg <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign sum_result = r_sum;
   assign sum_state  = r_sum_state;
   assign busy       = r_busy;
   assign negative   = r_neg;
   assign overflow   = r_ovf;
   assign term_count = r_terms;
   assign term_err   = r_term_err;

endmodule

// File: tb/tb_adder_accum_unit.sv
// Directed-vector bench for adder_accum_unit (WIDTH=12, MAX_TERMS=8); honours ADDER_SATURATE_EN.
module tb_adder_accum_unit;

   localparam int W = 12;
`ifdef ADDER_SATURATE_EN
   localparam int EXP_WRAP  = 8191;
   localparam int EXP_UNDER = 0;
`else
   localparam int EXP_WRAP  = 4093;
   localparam int EXP_UNDER = 8092;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] number1, number2;
   logic         op, mode, enable, clear;
   logic [W:0]   sum_result;
   logic         sum_state, busy, negative, overflow, term_err;
   logic [7:0]   term_count;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   adder_accum_unit #(.WIDTH(W), .MAX_TERMS(8)) dut (
      .clk(clk), .reset(reset), .number1(number1), .number2(number2),
      .op(op), .mode(mode), .enable(enable), .clear(clear),
      .sum_result(sum_result), .sum_state(sum_state), .busy(busy),
      .negative(negative), .overflow(overflow), .term_count(term_count),
      .term_err(term_err)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Issues one operation and checks the busy/sum_state timeline through edge N+3.
   task automatic run_op(input string tag, input int a, input int b,
                         input logic o, input logic m, input logic scramble);
      @(negedge clk);
      number1 = a[W-1:0];
      number2 = b[W-1:0];
      op      = o;
      mode    = m;
      enable  = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      if (scramble) begin
         number1 = '1;
         number2 = '0;
         op      = ~o;
         mode    = ~m;
      end
      check({tag, ":busy_n0"}, int'(busy), 0);
      @(posedge clk); #1;
      check({tag, ":busy_n1"}, int'(busy), 1);
      check({tag, ":valid_n1"}, int'(sum_state), 0);
      @(posedge clk); #1;
      check({tag, ":busy_n2"}, int'(busy), 1);
      check({tag, ":valid_n2"}, int'(sum_state), 1);
      @(posedge clk); #1;
      check({tag, ":busy_n3"}, int'(busy), 0);
      check({tag, ":valid_n3"}, int'(sum_state), 0);
      $display("op %s: a=%0d b=%0d op=%0d mode=%0d -> sum=%0d neg=%0d ovf=%0d terms=%0d",
               tag, a, b, o, m, sum_result, negative, overflow, term_count);
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      $display("clear: terms=%0d ovf=%0d", term_count, overflow);
   endtask

   initial begin
      reset = 1'b0; number1 = '0; number2 = '0;
      op = 1'b0; mode = 1'b0; enable = 1'b0; clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst:sum", int'(sum_result), 0);
      check("rst:valid", int'(sum_state), 0);
      check("rst:busy", int'(busy), 0);
      check("rst:neg", int'(negative), 0);
      check("rst:ovf", int'(overflow), 0);
      check("rst:terms", int'(term_count), 0);
      check("rst:terr", int'(term_err), 0);
      $display("reset: outputs checked");
      reset = 1'b1;

      // Single mode
      run_op("add", 367, 980, 1'b0, 1'b0, 1'b0);
      check("add:sum", int'(sum_result), 1347);
      check("add:neg", int'(negative), 0);
      run_op("sub_pos", 300, 157, 1'b1, 1'b0, 1'b0);
      check("sub_pos:sum", int'(sum_result), 143);
      check("sub_pos:neg", int'(negative), 0);
      run_op("sub_neg", 157, 300, 1'b1, 1'b0, 1'b1);
      check("sub_neg:sum", int'(sum_result), 143);
      check("sub_neg:neg", int'(negative), 1);

      // Accumulate overflow
      pulse_clear();
      run_op("acc1", 4095, 0, 1'b0, 1'b1, 1'b0);
      check("acc1:sum", int'(sum_result), 4095);
      check("acc1:ovf", int'(overflow), 0);
      run_op("acc2", 4095, 0, 1'b0, 1'b1, 1'b1);
      check("acc2:sum", int'(sum_result), 8190);
      check("acc2:ovf", int'(overflow), 0);
      run_op("acc3", 4095, 0, 1'b0, 1'b1, 1'b0);
      check("acc3:sum", int'(sum_result), EXP_WRAP);
      check("acc3:ovf", int'(overflow), 1);
      check("acc3:terms", int'(term_count), 3);

      // Single op must leave accumulate state alone
      run_op("single_mid", 10, 4, 1'b1, 1'b0, 1'b0);
      check("single_mid:sum", int'(sum_result), 6);
      check("single_mid:ovf", int'(overflow), 1);
      check("single_mid:terms", int'(term_count), 3);

      // Accumulate underflow
      pulse_clear();
      check("clr:ovf", int'(overflow), 0);
      check("clr:terms", int'(term_count), 0);
      run_op("accu1", 100, 0, 1'b0, 1'b1, 1'b0);
      check("accu1:sum", int'(sum_result), 100);
      run_op("accu2", 200, 0, 1'b1, 1'b1, 1'b0);
      check("accu2:sum", int'(sum_result), EXP_UNDER);
      check("accu2:ovf", int'(overflow), 1);
      check("accu2:neg", int'(negative), 0);

      // Term limit
      pulse_clear();
      for (int k = 1; k <= 8; k++) begin
         run_op("lim", 1, 0, 1'b0, 1'b1, 1'b0);
         check("lim:sum", int'(sum_result), k);
      end
      check("lim:terms", int'(term_count), 8);
      @(negedge clk);
      number1 = 12'd1; op = 1'b0; mode = 1'b1; enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      check("refuse:terr", int'(term_err), 1);
      check("refuse:busy", int'(busy), 0);
      @(posedge clk); #1;
      check("refuse:terr_end", int'(term_err), 0);
      check("refuse:busy2", int'(busy), 0);
      check("refuse:sum", int'(sum_result), 8);
      check("refuse:terms", int'(term_count), 8);
      $display("refuse: terr pulse checked, sum=%0d terms=%0d", sum_result, term_count);

      // clear wins over enable
      @(negedge clk);
      clear = 1'b1; enable = 1'b1; mode = 1'b1; number1 = 12'd1;
      @(posedge clk); #1;
      clear = 1'b0; enable = 1'b0;
      check("clren:terms", int'(term_count), 0);
      check("clren:terr", int'(term_err), 0);
      @(posedge clk); #1;
      check("clren:busy1", int'(busy), 0);
      @(posedge clk); #1;
      check("clren:busy2", int'(busy), 0);
      check("clren:valid", int'(sum_state), 0);
      check("clren:sum", int'(sum_result), 8);
      $display("clear+enable: terms=%0d sum=%0d", term_count, sum_result);
      run_op("post_clr", 3, 0, 1'b0, 1'b1, 1'b0);
      check("post_clr:sum", int'(sum_result), 3);
      check("post_clr:terms", int'(term_count), 1);

      // Reset mid-operation
      @(negedge clk);
      number1 = 12'd1000; number2 = 12'd1000; op = 1'b0; mode = 1'b0; enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      reset  = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      check("midrst:valid", int'(sum_state), 0);
      check("midrst:busy", int'(busy), 0);
      check("midrst:sum", int'(sum_result), 0);
      check("midrst:terms", int'(term_count), 0);
      repeat (3) begin
         @(posedge clk); #1;
         check("midrst:no_valid", int'(sum_state), 0);
      end
      $display("mid-op reset: sum=%0d terms=%0d", sum_result, term_count);
      run_op("after_rst", 5, 6, 1'b0, 1'b0, 1'b0);
      check("after_rst:sum", int'(sum_result), 11);
      run_op("acc_rst", 7, 0, 1'b0, 1'b1, 1'b0);
      check("acc_rst:sum", int'(sum_result), 7);
      check("acc_rst:terms", int'(term_count), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
